// File: rtl/i2s_pattern_gen.sv
// i2s_pattern_gen: I2S / TDM test-pattern source for audio-path bring-up.
// Divides clk down to a bit clock and serialises one word per channel slot,
// MSB first. The word comes from one of four pattern sources: constant,
// per-channel ramp, 32-bit Galois LFSR, or a channel-ID/frame-count tag.
// Frames always run to completion; start and stop are frame aligned.
//
// Optional build macro: I2SGEN_LJ_EN adds i_lj (left-justified framing).
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   i_en            run request, sampled in IDLE and at each frame end
//   i_lj            (I2SGEN_LJ_EN only) 1 = left-justified framing
//   i_mode          0 const, 1 ramp, 2 LFSR, 3 channel-ID
//   i_const/i_step  constant word / ramp increment
//   o_bck           bit clock, low half first, held 0 while idle
//   o_lrck          word select (2 channels) or 1-bit frame sync (TDM)
//   o_dout          serial data, changes on the o_bck falling edge
//   o_frame_start   one-clk pulse at the start of bit 0 of each frame
//   o_busy          high while a frame is in progress
module i2s_pattern_gen #(
    parameter int WORD_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int CHANNELS = 2,
    parameter int BCK_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
`ifdef I2SGEN_LJ_EN
    input  logic              i_lj,
`endif
    input  logic [1:0]        i_mode,
    input  logic [WORD_W-1:0] i_const,
    input  logic [WORD_W-1:0] i_step,
    output logic              o_bck,
    output logic              o_lrck,
    output logic              o_dout,
    output logic              o_frame_start,
    output logic              o_busy
);
    localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
    localparam int PW = $clog2(SLOT_W);
    localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    localparam int FW = WORD_W - 8;

    localparam logic [DW-1:0] DIV_LAST  = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(BCK_DIV / 2 - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(SLOT_W - 1);
    localparam logic [PW-1:0] POS_W     = PW'(WORD_W);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CHANNELS - 1);
    localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                           state;
    logic [DW-1:0]                    div;
    logic [PW-1:0]                    pos;
    logic [CW-1:0]                    slot;
    logic [1:0]                       mode_q;
    logic [WORD_W-1:0]                const_q, step_q, sh;
    logic [CHANNELS-1:0][WORD_W-1:0]  acc;
    logic [31:0]                      lfsr;
    logic [FW-1:0]                    fcnt;
`ifdef I2SGEN_LJ_EN
    logic                             lj_q;
`endif

    // Next-bit decode: everything below describes the bit period that starts
    // on the coming edge (only meaningful when bit_edge is set).
    logic              div_end, frame_last, stop, bit_edge, first, lj_e;
    logic [PW-1:0]     np;
    logic [CW-1:0]     ns;
    logic [1:0]        mode_e;
    logic [WORD_W-1:0] const_e, word, sh_n;
    logic [FW-1:0]     fcnt_e;
    logic [31:0]       lfsr_nxt;
    logic              dout_n, lrck_n;

    always_comb begin
        div_end    = (div == DIV_LAST);
        frame_last = (state == RUN) && div_end && (pos == POS_LAST) && (slot == SLOT_LAST);
        stop       = frame_last && !i_en;
        bit_edge   = ((state == IDLE) && i_en) || ((state == RUN) && div_end && !stop);
        np = ((state == IDLE) || (pos == POS_LAST)) ? '0 : pos + 1'b1;
        ns = (state == IDLE) ? '0 :
             (pos != POS_LAST) ? slot :
             (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        first = (np == '0) && (ns == '0);
        // Frame-start edge uses the live inputs; they are latched on that same edge.
        mode_e  = first ? i_mode : mode_q;
        const_e = first ? i_const : const_q;
`ifdef I2SGEN_LJ_EN
        lj_e = first ? i_lj : lj_q;
`else
        lj_e = 1'b0;
`endif
        // Frame counter bumps on the edge that also starts the next frame.
        fcnt_e   = frame_last ? fcnt + 1'b1 : fcnt;
        lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        case (mode_e)
            2'd0:    word = const_e;
            2'd1:    word = acc[ns];
            2'd2:    word = lfsr[WORD_W-1:0];
            default: word = {8'(ns), fcnt_e};
        endcase
        dout_n = 1'b0;
        sh_n   = sh;
        if (np == '0) begin
            // Left-justified sends the MSB straight away; I2S sends a 0 first.
            dout_n = lj_e ? word[WORD_W-1] : 1'b0;
            sh_n   = lj_e ? (word << 1) : word;
        end else if (lj_e ? (np < POS_W) : (np <= POS_W)) begin
            dout_n = sh[WORD_W-1];
            sh_n   = sh << 1;
        end
        if (CHANNELS == 2) lrck_n = ns[0] ^ lj_e;
        else               lrck_n = first;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            div           <= '0;
            pos           <= '0;
            slot          <= '0;
            mode_q        <= '0;
            const_q       <= '0;
            step_q        <= '0;
            sh            <= '0;
            acc           <= '0;
            lfsr          <= 32'h0000_0001;
            fcnt          <= '0;
            o_bck         <= 1'b0;
            o_lrck        <= 1'b0;
            o_dout        <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
`ifdef I2SGEN_LJ_EN
            lj_q          <= 1'b0;
`endif
        end else begin
            o_frame_start <= 1'b0;
            if (state == RUN) begin
                div <= div_end ? '0 : div + 1'b1;
                if (div == DIV_HALF) o_bck <= 1'b1;
                if (div_end) begin
                    o_bck <= 1'b0;
                    // Ramp channel advances once its slot has been sent.
                    if ((pos == POS_LAST) && (mode_q == 2'd1))
                        acc[slot] <= acc[slot] + step_q;
                    if (frame_last) fcnt <= fcnt + 1'b1;
                end
            end
            if (bit_edge) begin
                state         <= RUN;
                o_busy        <= 1'b1;
                pos           <= np;
                slot          <= ns;
                o_lrck        <= lrck_n;
                o_dout        <= dout_n;
                sh            <= sh_n;
                o_frame_start <= first;
                if (first) begin
                    mode_q  <= i_mode;
                    const_q <= i_const;
                    step_q  <= i_step;
`ifdef I2SGEN_LJ_EN
                    lj_q    <= i_lj;
`endif
                end
                if ((np == '0) && (mode_e == 2'd2)) lfsr <= lfsr_nxt;
            end
            if (stop) begin
                state  <= IDLE;
                o_busy <= 1'b0;
                o_lrck <= 1'b0;
                o_dout <= 1'b0;
                pos    <= '0;
                slot   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_pattern_gen.sv
`timescale 1ns/1ps
module tb_i2s_pattern_gen;
    localparam int CLK = 10;
    localparam logic [31:0] MASK = 32'h8020_0003;

    logic clk = 1'b0;
    always #(CLK/2) clk = ~clk;

    logic        rst_n = 1'b0;
    logic        en = 1'b0, t_en = 1'b0;
    logic [1:0]  mode = '0;
    logic [23:0] cnst = '0, step = '0;
    logic        o_bck, o_lrck, o_dout, o_fs, o_busy;
    logic        t_bck, t_lrck, t_dout, t_fs, t_busy;

    i2s_pattern_gen u_dut (
        .clk(clk), .rst_n(rst_n), .i_en(en),
`ifdef I2SGEN_LJ_EN
        .i_lj(1'b0),
`endif
        .i_mode(mode), .i_const(cnst), .i_step(step),
        .o_bck(o_bck), .o_lrck(o_lrck), .o_dout(o_dout),
        .o_frame_start(o_fs), .o_busy(o_busy));

    i2s_pattern_gen #(.CHANNELS(4)) u_tdm (
        .clk(clk), .rst_n(rst_n), .i_en(t_en),
`ifdef I2SGEN_LJ_EN
        .i_lj(1'b0),
`endif
        .i_mode(2'd3), .i_const(24'h0), .i_step(24'h0),
        .o_bck(t_bck), .o_lrck(t_lrck), .o_dout(t_dout),
        .o_frame_start(t_fs), .o_busy(t_busy));

    int pass_cnt = 0, chk_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference pattern state
    logic [23:0] acc_m[2];
    logic [31:0] lfsr_m;
    logic [15:0] fcnt_m, tfcnt_m;
    logic [23:0] exp_q[$];
    logic [23:0] texp_q[$];

    task automatic model_reset();
        acc_m[0] = '0; acc_m[1] = '0; lfsr_m = 32'h1; fcnt_m = '0; tfcnt_m = '0;
    endtask

    task automatic model_frame(input logic [1:0] m, input logic [23:0] c, input logic [23:0] s,
                               output logic [23:0] w0, output logic [23:0] w1);
        logic [23:0] w[2];
        for (int ch = 0; ch < 2; ch++) begin
            case (m)
                2'd0: w[ch] = c;
                2'd1: begin w[ch] = acc_m[ch]; acc_m[ch] = acc_m[ch] + s; end
                2'd2: begin
                    w[ch] = lfsr_m[23:0];
                    lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ MASK) : (lfsr_m >> 1);
                end
                default: w[ch] = {8'(ch), fcnt_m};
            endcase
        end
        fcnt_m++;
        w0 = w[0]; w1 = w[1];
    endtask

    // I2S monitor: rebuild each frame from bck rising edges and score it
    logic b_bits[64], b_lr[64];
    initial begin
        int idx = -1, gap = 0, bad;
        logic bp = 1'b0;
        logic [23:0] w;
        forever begin
            @(negedge clk);
            gap++;
            if (!rst_n) begin
                idx = -1; bp = 1'b0;
            end else begin
                if (o_fs) idx = 0;
                if (o_bck && !bp && idx >= 0 && idx < 64) begin
                    if (idx > 0 && gap != 4) $display("FAIL bck_period: got %0d clks, expected 4", gap);
                    if (idx > 0) begin chk_cnt++; if (gap == 4) pass_cnt++; end
                    gap = 0;
                    b_bits[idx] = o_dout; b_lr[idx] = o_lrck;
                    idx++;
                    if (idx == 64) begin
                        bad = 0;
                        for (int b = 0; b < 64; b++) begin
                            if (b_lr[b] !== (b >= 32)) bad++;
                            if (((b % 32) == 0 || (b % 32) > 24) && b_bits[b] !== 1'b0) bad++;
                        end
                        chk("i2s_framing_bad_bits", bad, 0);
                        for (int s = 0; s < 2; s++) begin
                            w = '0;
                            for (int p = 1; p <= 24; p++) w = {w[22:0], b_bits[s*32+p]};
                            if (exp_q.size() == 0) chk("i2s_unexpected_word", w, 32'hDEAD);
                            else chk($sformatf("i2s_word_slot%0d", s), w, exp_q.pop_front());
                        end
                        idx = -1;
                    end
                end
                bp = o_bck;
            end
        end
    end

    // Drive one run of nfr frames; frame 0 may use table-supplied expectations
    task automatic run_i2s(input logic [1:0] m, input logic [23:0] c, input logic [23:0] s,
                           input int nfr, input logic use_exp, input logic [23:0] el, input logic [23:0] er);
        logic [23:0] w0, w1;
        int seen = 0, cyc = 0, last = 0, cnt = 0, bad = 0;
        mode = m; cnst = c; step = s;
        for (int f = 0; f < nfr; f++) begin
            model_frame(m, c, s, w0, w1);
            if (f == 0 && use_exp) begin w0 = el; w1 = er; end
            exp_q.push_back(w0); exp_q.push_back(w1);
        end
        en = 1'b1;
        while (seen < nfr && cyc < 400 * nfr) begin
            @(posedge clk); #1; cyc++;
            if (o_fs) begin
                if (seen > 0) chk("frame_period_clks", cyc - last, 256);
                last = cyc; seen++;
            end
        end
        chk("frames_started", seen, nfr);
        en = 1'b0;
        // Mid-frame input changes must not affect the frame in flight
        mode = 2'($urandom); cnst = 24'($urandom); step = 24'($urandom);
        while (o_busy && cnt < 1000) begin @(posedge clk); #1; cnt++; end
        chk("busy_fall_clks", cnt, 256);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (o_bck || o_lrck || o_dout || o_busy || o_fs) bad++;
        end
        chk("idle_outputs_active", bad, 0);
        chk("scoreboard_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // TDM capture: one frame of 128 bck periods, 4 slots
    task automatic capture_tdm(input logic stop, output time ts);
        logic bits[128], lr[128];
        logic bp;
        int n = 0, cnt = 0, bad = 0;
        logic [23:0] w;
        ts = 0;
        while (!t_fs && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("tdm_frame_start_seen", t_fs, 1);
        ts = $time;
        if (stop) t_en = 1'b0;
        bp = t_bck; cnt = 0;
        while (n < 128 && cnt < 1000) begin
            @(negedge clk); cnt++;
            if (t_bck && !bp) begin bits[n] = t_dout; lr[n] = t_lrck; n++; end
            bp = t_bck;
        end
        chk("tdm_bits_captured", n, 128);
        for (int b = 0; b < 128; b++) begin
            if (b < n && lr[b] !== (b == 0)) bad++;
            if (b < n && ((b % 32) == 0 || (b % 32) > 24) && bits[b] !== 1'b0) bad++;
        end
        chk("tdm_framing_bad_bits", bad, 0);
        for (int s = 0; s < 4; s++) begin
            w = '0;
            for (int p = 1; p <= 24; p++) w = {w[22:0], bits[s*32+p]};
            if (texp_q.size() == 0) chk("tdm_unexpected_word", w, 32'hDEAD);
            else chk($sformatf("tdm_word_slot%0d", s), w, texp_q.pop_front());
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] cnst;
        logic [23:0] step;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;
    vec_t vecs[7];

    initial begin
        time ta, tb;
        int cnt;
        vecs[0] = '{2'd0, 24'hA5A5A5, 24'h0, 24'hA5A5A5, 24'hA5A5A5};
        vecs[1] = '{2'd0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
        vecs[2] = '{2'd0, 24'h000001, 24'h0, 24'h000001, 24'h000001};
        vecs[3] = '{2'd0, 24'h800000, 24'h0, 24'h800000, 24'h800000};
        vecs[4] = '{2'd3, 24'h123456, 24'h0, 24'h000004, 24'h010004};
        vecs[5] = '{2'd3, 24'h000000, 24'h5, 24'h000005, 24'h010005};
        vecs[6] = '{2'd0, 24'h5A5A5A, 24'h0, 24'h5A5A5A, 24'h5A5A5A};
        model_reset();

        #12;
        chk("reset_outputs", {o_bck, o_lrck, o_dout, o_fs, o_busy, t_bck, t_lrck, t_dout, t_fs, t_busy}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        foreach (vecs[i]) run_i2s(vecs[i].mode, vecs[i].cnst, vecs[i].step, 1, 1'b1, vecs[i].exp_l, vecs[i].exp_r);

        // Ramp, held enable: 0/0, 1/1, 2/2
        run_i2s(2'd1, 24'h0, 24'h1, 3, 1'b1, 24'h0, 24'h0);
        // LFSR from its reset seed, then free-running
        run_i2s(2'd2, 24'h0, 24'h0, 1, 1'b1, 24'h000001, 24'h200003);
        run_i2s(2'd2, 24'h0, 24'h0, 2, 1'b1, 24'h300002, 24'h180001);

        // TDM, 4 slots, channel-ID words
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) texp_q.push_back({8'(s), tfcnt_m});
            tfcnt_m++;
        end
        t_en = 1'b1;
        capture_tdm(1'b0, ta);
        capture_tdm(1'b1, tb);
        chk("tdm_frame_period_ns", 32'(tb - ta), 128 * 4 * CLK);
        cnt = 0;
        while (t_busy && cnt < 1000) begin @(posedge clk); #1; cnt++; end
        chk("tdm_busy_low", t_busy, 0);

        // Reset in the middle of bit 40
        mode = 2'd2; en = 1'b1;
        cnt = 0;
        @(posedge clk); #1;
        while (!o_fs && cnt < 100) begin @(posedge clk); #1; cnt++; end
        chk("pre_reset_frame_start", o_fs, 1);
        repeat (160) @(posedge clk);
        #2;
        chk("bit40_lrck_right", o_lrck, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {o_bck, o_lrck, o_dout, o_fs, o_busy}, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        run_i2s(2'd2, 24'h0, 24'h0, 1, 1'b1, 24'h000001, 24'h200003);

        // Ramp wrap from fresh accumulators: 0, FFFFFF, FFFFFE
        run_i2s(2'd1, 24'h0, 24'hFFFFFF, 3, 1'b0, 24'h0, 24'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end
endmodule
